// File: rtl/smg_scan_ctrl_if.sv
// Interface bundling the data/control inputs and registered display outputs
// of the seven-segment scan controller.
interface smg_scan_ctrl_if #(
    parameter int DIGITS = 6
);
    logic [4*DIGITS-1:0] idata;
    logic [DIGITS-1:0]   idp;
    logic                lz_en;
    logic                en;
    logic [3:0]          odigit;
    logic                odp;
    logic                oblank;
    logic [DIGITS-1:0]   osel;
    logic                frame_tick;

    modport master (
        output idata, idp, lz_en, en,
        input  odigit, odp, oblank, osel, frame_tick
    );

    modport slave (
        input  idata, idp, lz_en, en,
        output odigit, odp, oblank, osel, frame_tick
    );
endinterface

// File: rtl/smg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: snapshots a nibble word once per
// frame, then walks the digits with a programmable dwell and an optional
// blank gap, applying leading-zero suppression. All outputs are registered
// from the next-state values so nothing leaves the block combinationally.
module smg_scan_ctrl #(
    parameter int DIGITS         = 6,
    parameter int T_DWELL        = 5000,
    parameter int T_BLANK        = 250,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    smg_scan_ctrl_if.slave bus
);

    localparam int CNT_TOP  = (T_DWELL > T_BLANK) ? T_DWELL : T_BLANK;
    localparam int CNT_SPAN = (CNT_TOP > 2) ? CNT_TOP : 2;
    localparam int CW       = $clog2(CNT_SPAN);
    localparam int KW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     DWELL_LAST = CW'(T_DWELL - 1);
    localparam logic [CW-1:0]     BLANK_LAST = (T_BLANK > 0) ? CW'(T_BLANK - 1) : '0;
    localparam logic [KW-1:0]     K_LAST     = KW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_IDLE   = {DIGITS{SEL_ACTIVE_LOW}};

    typedef enum logic [1:0] {IDLE, LOAD, SHOW, GAP} state_t;

    state_t                state, state_nxt;
    logic [KW-1:0]         k, k_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [4*DIGITS-1:0]   snap_data, snap_data_nxt;
    logic [DIGITS-1:0]     snap_dp, snap_dp_nxt;
    logic                  show_nxt;
    logic                  tick_nxt;
    logic [DIGITS-1:0]     onehot_nxt;

    // Digit 0 is the most significant nibble of the packed word.
    function automatic logic [3:0] nibble_of(input logic [4*DIGITS-1:0] d,
                                             input logic [KW-1:0] idx);
        return d[4*(DIGITS-1-int'(idx)) +: 4];
    endfunction

    function automatic logic dp_of(input logic [DIGITS-1:0] p,
                                   input logic [KW-1:0] idx);
        return p[DIGITS-1-int'(idx)];
    endfunction

    // A digit is a leading zero when it and every digit to its left are zero
    // with no decimal point; the rightmost digit is always shown.
    function automatic logic lz_blank(input logic [4*DIGITS-1:0] d,
                                      input logic [DIGITS-1:0] p,
                                      input logic [KW-1:0] idx);
        logic lead_zero;
        lead_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i <= int'(idx) && (d[4*(DIGITS-1-i) +: 4] != 4'd0 || p[DIGITS-1-i]))
                lead_zero = 1'b0;
        end
        return lead_zero && (int'(idx) < DIGITS - 1);
    endfunction

    // Next-state, next-digit and dwell-counter decode; en low overrides all.
    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        cnt_nxt       = cnt;
        snap_data_nxt = snap_data;
        snap_dp_nxt   = snap_dp;
        case (state)
            IDLE: begin
                state_nxt = LOAD;
                k_nxt     = '0;
                cnt_nxt   = '0;
            end
            LOAD: begin
                state_nxt     = SHOW;
                k_nxt         = '0;
                cnt_nxt       = '0;
                snap_data_nxt = bus.idata;
                snap_dp_nxt   = bus.idp;
            end
            SHOW: begin
                if (cnt == DWELL_LAST) begin
                    cnt_nxt = '0;
                    if (T_BLANK != 0)
                        state_nxt = GAP;
                    else if (k == K_LAST)
                        state_nxt = LOAD;
                    else
                        k_nxt = k + KW'(1);
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt == BLANK_LAST) begin
                    cnt_nxt = '0;
                    if (k == K_LAST) begin
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = SHOW;
                        k_nxt     = k + KW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!bus.en) begin
            state_nxt = IDLE;
            k_nxt     = '0;
            cnt_nxt   = '0;
        end
        show_nxt   = (state_nxt == SHOW) &&
                     !(bus.lz_en && lz_blank(snap_data_nxt, snap_dp_nxt, k_nxt));
        onehot_nxt = DIGITS'(1) << k_nxt;
        // Flag the cycle about to be entered if it is the final one of the frame.
        tick_nxt   = (k_nxt == K_LAST) &&
                     ((state_nxt == GAP && cnt_nxt == BLANK_LAST) ||
                      (state_nxt == SHOW && T_BLANK == 0 && cnt_nxt == DWELL_LAST));
    end

    // State registers and registered display outputs; reset dominates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            k              <= '0;
            cnt            <= '0;
            snap_data      <= '0;
            snap_dp        <= '0;
            bus.osel       <= SEL_IDLE;
            bus.oblank     <= 1'b1;
            bus.odigit     <= 4'd0;
            bus.odp        <= 1'b0;
            bus.frame_tick <= 1'b0;
        end else begin
            state          <= state_nxt;
            k              <= k_nxt;
            cnt            <= cnt_nxt;
            snap_data      <= snap_data_nxt;
            snap_dp        <= snap_dp_nxt;
            bus.osel       <= show_nxt ? (SEL_IDLE ^ onehot_nxt) : SEL_IDLE;
            bus.oblank     <= !show_nxt;
            bus.odigit     <= show_nxt ? nibble_of(snap_data_nxt, k_nxt) : 4'd0;
            bus.odp        <= show_nxt ? dp_of(snap_dp_nxt, k_nxt) : 1'b0;
            bus.frame_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Bench for smg_scan_ctrl: two instances (gap/active-low and no-gap/active-high)
// share the same stimulus and are compared every cycle with a frame-position
// model, plus directed literal expectations.
module tb_smg_scan_ctrl;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] idata;
    logic [5:0]  idp;
    logic        lz_en;
    logic        en;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    smg_scan_ctrl_if #(.DIGITS(6)) b0 ();
    smg_scan_ctrl_if #(.DIGITS(6)) b1 ();

    assign b0.idata = idata;
    assign b0.idp   = idp;
    assign b0.lz_en = lz_en;
    assign b0.en    = en;
    assign b1.idata = idata;
    assign b1.idp   = idp;
    assign b1.lz_en = lz_en;
    assign b1.en    = en;

    smg_scan_ctrl #(.DIGITS(6), .T_DWELL(TD), .T_BLANK(1), .SEL_ACTIVE_LOW(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    smg_scan_ctrl #(.DIGITS(6), .T_DWELL(TD), .T_BLANK(0), .SEL_ACTIVE_LOW(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );

    // Model state: whether a frame is running and the cycle position inside it
    // (0 = LOAD cycle), plus the frame's snapshot.
    bit          m_active [2];
    int          m_pos    [2];
    logic [23:0] m_snapd  [2];
    logic [5:0]  m_snapp  [2];
    logic [12:0] m_exp    [2];

    // Frame observation for instance 0 and tick timing for both.
    int          acc_shown = 0, acc_dp = 0, frame_shown = 0, frame_dp = 0;
    logic [63:0] acc_word = '0, frame_word = '0;
    bit          prev_blank = 1'b1;
    int          tick_prev [2] = '{0, 0};
    int          tick_last [2] = '{0, 0};
    int          tick_cnt0 = 0;
    logic [12:0] act;

    // Expected {osel, odigit, odp, oblank, frame_tick} from the frame position.
    function automatic logic [12:0] model_out(input int tbl, input bit low, input bit active,
                                              input int pos, input logic [23:0] d,
                                              input logic [5:0] p, input logic lz);
        logic [5:0] idle_sel, sel;
        int per, full, q, k, r;
        bit tick, blank;
        idle_sel = low ? 6'b111111 : 6'b000000;
        if (!active || pos == 0) return {idle_sel, 4'd0, 1'b0, 1'b1, 1'b0};
        per   = TD + tbl;
        full  = 1 + 6 * per;
        q     = pos - 1;
        k     = q / per;
        r     = q % per;
        tick  = (pos == full - 1);
        blank = 1'b0;
        if (lz && k < 5) begin
            blank = 1'b1;
            for (int j = 0; j <= k; j++)
                if (d[4*(5-j) +: 4] != 4'd0 || p[5-j]) blank = 1'b0;
        end
        if (r < TD && !blank) begin
            sel = low ? ~(6'b000001 << k) : (6'b000001 << k);
            return {sel, d[4*(5-k) +: 4], p[5-k], 1'b0, tick};
        end
        return {idle_sel, 4'd0, 1'b0, 1'b1, tick};
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic wait_tick0();
        int  n;
        bit  got;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            #1;
            n++;
            if (b0.frame_tick) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL wait_frame_tick timed out after %0d cycles", n);
        end
    endtask

    task automatic wait_sel0(input logic [5:0] s);
        int  n;
        bit  got;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            #1;
            n++;
            if (b0.osel == s) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL wait_osel timed out waiting for %b", s);
        end
    endtask

    // Model advance on every active edge, using the inputs the DUT sees.
    initial begin
        int tbl, full;
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                tbl  = (i == 0) ? 1 : 0;
                full = 1 + 6 * (TD + tbl);
                if (!rst_n) begin
                    m_active[i] = 1'b0;
                    m_pos[i]    = 0;
                    m_snapd[i]  = '0;
                    m_snapp[i]  = '0;
                end else if (!en) begin
                    m_active[i] = 1'b0;
                end else if (!m_active[i]) begin
                    m_active[i] = 1'b1;
                    m_pos[i]    = 0;
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                    if (m_pos[i] == full) m_pos[i] = 0;
                    if (m_pos[i] == 1) begin
                        m_snapd[i] = idata;
                        m_snapp[i] = idp;
                    end
                end
                m_exp[i] = model_out(tbl, (i == 0), m_active[i], m_pos[i],
                                     m_snapd[i], m_snapp[i], lz_en);
            end
        end
    end

    // Compare both instances against the model every cycle, then gather
    // per-frame observations.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                for (int i = 0; i < 2; i++) begin
                    act = (i == 0) ? {b0.osel, b0.odigit, b0.odp, b0.oblank, b0.frame_tick}
                                   : {b1.osel, b1.odigit, b1.odp, b1.oblank, b1.frame_tick};
                    checks++;
                    if (act !== m_exp[i]) begin
                        failures++;
                        $display("FAIL model_cmp inst%0d cyc=%0d actual=%h required=%h",
                                 i, cyc, act, m_exp[i]);
                    end
                end
                if (!rst_n) begin
                    acc_shown  = 0;
                    acc_dp     = 0;
                    acc_word   = '0;
                    prev_blank = 1'b1;
                end else begin
                    if (!b0.oblank) begin
                        acc_shown++;
                        if (b0.odp) acc_dp++;
                        if (prev_blank) acc_word = {acc_word[59:0], b0.odigit};
                    end
                    prev_blank = b0.oblank;
                    if (b0.frame_tick) begin
                        frame_shown = acc_shown;
                        frame_dp    = acc_dp;
                        frame_word  = acc_word;
                        acc_shown   = 0;
                        acc_dp      = 0;
                        acc_word    = '0;
                        tick_cnt0++;
                        tick_prev[0] = tick_last[0];
                        tick_last[0] = cyc;
                    end
                end
                if (b1.frame_tick) begin
                    tick_prev[1] = tick_last[1];
                    tick_last[1] = cyc;
                end
            end
        end
    end

    // Directed sequence followed by randomized stimulus.
    initial begin
        int ticks_before;
        int en_off;
        logic [23:0] masks [4];
        masks = '{24'hFFFFFF, 24'h0000FF, 24'h000F0F, 24'h00000F};

        rst_n = 1'b0;
        en    = 1'b1;
        idata = 24'h123456;
        idp   = 6'b000000;
        lz_en = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_osel0",   b0.osel, 6'b111111);
        check("reset_oblank0", b0.oblank, 1'b1);
        check("reset_tick0",   b0.frame_tick, 1'b0);
        check("reset_odigit0", b0.odigit, 4'd0);
        check("reset_osel1",   b1.osel, 6'b000000);
        rst_n = 1'b1;

        @(posedge clk);
        #1;
        check("load_osel0", b0.osel, 6'b111111);
        @(posedge clk);
        #1;
        check("first_show_osel0",  b0.osel, 6'b111110);
        check("first_show_digit0", b0.odigit, 4'h1);
        check("first_show_osel1",  b1.osel, 6'b000001);

        // Frame 1: plain scan.
        wait_tick0();
        check("scan_word",  frame_word, 64'h123456);
        check("scan_shown", frame_shown, 24);
        lz_en = 1'b1;
        idata = 24'h000305;

        wait_tick0();
        check("period_gap",   tick_last[0] - tick_prev[0], 31);
        check("period_nogap", tick_last[1] - tick_prev[1], 25);
        check("lz305_word",  frame_word, 64'h305);
        check("lz305_shown", frame_shown, 12);
        idata = 24'h000000;

        wait_tick0();
        check("lz0_word",  frame_word, 64'h0);
        check("lz0_shown", frame_shown, 4);
        idata = 24'h000005;
        idp   = 6'b000010;

        wait_tick0();
        check("lzdp_word",  frame_word, 64'h05);
        check("lzdp_shown", frame_shown, 8);
        check("lzdp_dp",    frame_dp, 4);
        lz_en = 1'b0;
        idata = 24'h123456;
        idp   = 6'b000000;

        // Snapshot coherence: change the word while digit 2 is shown.
        wait_sel0(6'b111011);
        idata = 24'hABCDEF;
        wait_tick0();
        check("snap_old_word", frame_word, 64'h123456);
        wait_tick0();
        check("snap_new_word", frame_word, 64'hABCDEF);

        // Enable drop mid-frame.
        wait_sel0(6'b110111);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("en_off_osel0",   b0.osel, 6'b111111);
        check("en_off_oblank0", b0.oblank, 1'b1);
        check("en_off_osel1",   b1.osel, 6'b000000);
        ticks_before = tick_cnt0;
        repeat (40) @(posedge clk);
        #1;
        check("en_off_no_tick", tick_cnt0, ticks_before);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("reen_load_osel0", b0.osel, 6'b111111);
        @(posedge clk);
        #1;
        check("reen_show_osel0",  b0.osel, 6'b111110);
        check("reen_show_digit0", b0.odigit, 4'hA);

        // Randomized phase; the per-cycle model comparison does the checking.
        lz_en  = 1'b1;
        en_off = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            #1;
            rst_n = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
            if (en_off > 0) begin
                en_off--;
                if (en_off == 0) en = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                en     = 1'b0;
                en_off = $urandom_range(1, 20);
            end
            if ($urandom_range(0, 15) == 0)
                idata = 24'($urandom) & masks[$urandom_range(0, 3)];
            if ($urandom_range(0, 31) == 0)
                idp = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            if ($urandom_range(0, 63) == 0)
                lz_en = ~lz_en;
        end

        rst_n = 1'b1;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
